multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS core. Sequences fetch/decode/execute/memory/writeback
//  and drives every datapath select and write enable, including the link-writeback select
//  (link_sel: 1 = write PC, 0 = ALU/memory result) used by JAL. Talks to unified memory
//  through a req/ack handshake with a timeout watchdog.
// PARAMETERS
//  TIMEOUT  15  max wait cycles for mem_ack per access; 0 disables the watchdog
//  CW       4   width of wait counter; must hold TIMEOUT
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  funct        in   6  IR[5:0], passed through for R-type ALU decode
//  zero         in   1  ALU zero flag (valid in EXEC)
//  mem_ack      in   1  memory done; read data valid same cycle
//  mem_req      out  1  memory request, held until ack or timeout
//  mem_we       out  1  memory write (valid with mem_req)
//  ir_we        out  1  load IR
//  pc_we        out  1  load PC
//  pc_src       out  2  0=PC+4, 1=branch target, 2=jump target
//  reg_we       out  1  register-file write
//  reg_dst      out  2  0=rt, 1=rd, 2=$31
//  wb_mem_sel   out  1  1=writeback from memory data, 0=ALU
//  link_sel     out  1  1=writeback PC (link), 0=wb_mem_sel result
//  alu_op       out  2  0=add, 1=sub, 2=decode funct
//  illegal_op   out  1  one-cycle pulse on unsupported opcode
//  bus_err      out  1  one-cycle pulse on handshake timeout
//  state        out  3  current state, debug
// BEHAVIOUR
//  - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, LINK=5. One state per cycle except waits.
//  - Reset: state<=FETCH, wait counter<=0; while rst=1 all outputs 0. First post-reset cycle is FETCH.
//  - Outputs decode combinationally from state + opcode + zero + mem_ack; unlisted outputs 0.
//  - FETCH: mem_req=1, mem_we=0. On mem_ack: ir_we=1, pc_we=1, pc_src=0 -> DECODE. Else stay.
//  - DECODE: opcode 0x00 R, 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq -> EXEC;
//    0x02 j: pc_we=1, pc_src=2 -> FETCH; 0x03 jal -> LINK; other: illegal_op=1 -> FETCH.
//  - EXEC: alu_op=2 (R), 1 (beq), 0 (addi/lw/sw). beq: pc_we=zero, pc_src=1 -> FETCH;
//    lw/sw -> MEM; R/addi -> WB.
//  - MEM: mem_req=1, mem_we=(sw). On ack: sw -> FETCH, lw -> WB. Else stay.
//  - WB: reg_we=1, reg_dst=(R?1:0), wb_mem_sel=(lw), link_sel=0 -> FETCH.
//  - LINK: reg_we=1, reg_dst=2, link_sel=1, pc_we=1, pc_src=2 -> FETCH. PC already holds
//    PC+4 from FETCH, so link value is return address; reg write and PC load share the cycle.
//  - Latency (ack same cycle as req): R/addi 4, lw 5, sw 4, beq 3, j 2, jal 3 cycles.
//  - Watchdog: counter clears on entry to FETCH/MEM and on ack; increments each waiting cycle
//    with mem_req=1 and mem_ack=0. When counter==TIMEOUT and no ack: bus_err=1, mem_req
//    still 1 that cycle, no enables, -> FETCH. PC not written, so fetch retries same address.
//  - mem_ack outside FETCH/MEM is ignored. Ack arriving in the timeout cycle wins (no bus_err).
//  - rst mid-instruction: next state FETCH, no partial writes complete after rst sampled.
// TESTING
//  - Reset: rst=1 2 cycles -> all outputs 0; release -> state=0, mem_req=1.
//  - addi, ack immediate -> states 0,1,2,4,0; WB cycle reg_we=1, reg_dst=0, alu_op=0.
//  - lw, mem_ack delayed 3 cycles in MEM -> mem_req held 4 cycles in MEM, then WB with wb_mem_sel=1.
//  - jal -> LINK cycle: link_sel=1, reg_dst=2, reg_we=1, pc_we=1, pc_src=2; j -> no reg_we.
//  - beq zero=1 vs zero=0 -> pc_we=1/0 with pc_src=1 in EXEC; opcode 0x3F -> illegal_op pulse, FETCH.
//  - TIMEOUT=15, mem_ack never -> bus_err after 16 req cycles, no pc_we; ack on cycle 16 -> no bus_err.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Unified-memory handshake between the control FSM and the memory.
//   mem_req  : request, held until mem_ack or watchdog timeout
//   mem_we   : write strobe, qualified by mem_req
//   mem_ack  : memory done; read data valid in the same cycle
// Modports: master = controller side, slave = memory side.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS core: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write enable. Memory traffic goes through a req/ack
// handshake guarded by a wait-cycle watchdog.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   opcode, funct   IR fields (funct is consumed by the ALU decoder, not here)
//   zero            ALU zero flag, used by beq in EXEC
//   bus             memory handshake (mem_req/mem_we out, mem_ack in)
//   ir_we, pc_we    IR / PC load enables; pc_src selects PC+4 / branch / jump target
//   reg_we, reg_dst register-file write enable and destination (rt / rd / $31)
//   wb_mem_sel      writeback from memory data instead of ALU
//   link_sel        writeback PC (jal link) instead of wb_mem_sel result
//   alu_op          add / sub / decode funct
//   illegal_op      one-cycle pulse on an unsupported opcode
//   bus_err         one-cycle pulse on handshake timeout
//   state           current state, debug
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CW      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               opcode,
    input  logic [5:0]               funct,
    input  logic                     zero,
    multicycle_ctrl_if.master        bus,
    output logic                     ir_we,
    output logic                     pc_we,
    output logic [1:0]               pc_src,
    output logic                     reg_we,
    output logic [1:0]               reg_dst,
    output logic                     wb_mem_sel,
    output logic                     link_sel,
    output logic [1:0]               alu_op,
    output logic                     illegal_op,
    output logic                     bus_err,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StLink   = 3'd5
    } state_e;

    localparam logic [5:0] OpR    = 6'h00;
    localparam logic [5:0] OpAddi = 6'h08;
    localparam logic [5:0] OpLw   = 6'h23;
    localparam logic [5:0] OpSw   = 6'h2B;
    localparam logic [5:0] OpBeq  = 6'h04;
    localparam logic [5:0] OpJ    = 6'h02;
    localparam logic [5:0] OpJal  = 6'h03;

    localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout;
    logic          is_r, is_lw, is_sw, is_beq;

    // funct only matters to the ALU decoder downstream
    logic unused_funct;
    assign unused_funct = ^funct;

    assign is_r   = (opcode == OpR);
    assign is_lw  = (opcode == OpLw);
    assign is_sw  = (opcode == OpSw);
    assign is_beq = (opcode == OpBeq);

    // TIMEOUT == 0 disables the watchdog; the counter then just wraps harmlessly
    assign timeout = (TIMEOUT != 0) && (cnt_q == TimeoutVal);

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;  // cleared on every state change and on ack
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        reg_we      = 1'b0;
        reg_dst     = 2'd0;
        wb_mem_sel  = 1'b0;
        link_sel    = 1'b0;
        alu_op      = 2'd0;
        illegal_op  = 1'b0;
        bus_err     = 1'b0;

        case (state_q)
            StFetch: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    // PC untouched, so the retry fetches the same address
                    bus_err = 1'b1;
                    state_d = StFetch;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDecode: begin
                case (opcode)
                    OpR, OpAddi, OpLw, OpSw, OpBeq: state_d = StExec;
                    OpJ: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'd2;
                        state_d = StFetch;
                    end
                    OpJal:   state_d = StLink;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StFetch;
                    end
                endcase
            end
            StExec: begin
                alu_op = is_r ? 2'd2 : (is_beq ? 2'd1 : 2'd0);
                if (is_beq) begin
                    pc_we   = zero;
                    pc_src  = 2'd1;
                    state_d = StFetch;
                end else if (is_lw || is_sw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = is_sw;
                if (bus.mem_ack) begin
                    state_d = is_sw ? StFetch : StWb;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    state_d = StFetch;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWb: begin
                reg_we     = 1'b1;
                reg_dst    = is_r ? 2'd1 : 2'd0;
                wb_mem_sel = is_lw;
                state_d    = StFetch;
            end
            StLink: begin
                // PC already holds PC+4, so it is the return address written to $31
                reg_we   = 1'b1;
                reg_dst  = 2'd2;
                link_sel = 1'b1;
                pc_we    = 1'b1;
                pc_src   = 2'd2;
                state_d  = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Reset forces every output low so no partial write completes
        if (rst) begin
            state_d     = StFetch;
            cnt_d       = '0;
            bus.mem_req = 1'b0;
            bus.mem_we  = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_src      = 2'd0;
            reg_we      = 1'b0;
            reg_dst     = 2'd0;
            wb_mem_sel  = 1'b0;
            link_sel    = 1'b0;
            alu_op      = 2'd0;
            illegal_op  = 1'b0;
            bus_err     = 1'b0;
        end
    end

    assign state = rst ? 3'd0 : state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded from its class into an expected
// cycle trace (state + all outputs + ack to drive), then played against the DUT.
module tb_multicycle_ctrl;

    localparam int TMO = 15;

    localparam logic [5:0] OpR    = 6'h00;
    localparam logic [5:0] OpAddi = 6'h08;
    localparam logic [5:0] OpLw   = 6'h23;
    localparam logic [5:0] OpSw   = 6'h2B;
    localparam logic [5:0] OpBeq  = 6'h04;
    localparam logic [5:0] OpJ    = 6'h02;
    localparam logic [5:0] OpJal  = 6'h03;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic       wbm, link;
        logic [1:0] alu;
        logic       ill, berr;
    } out_t;

    typedef struct {
        out_t o;
        logic ack;
    } step_t;

    logic       clk, rst, zero;
    logic [5:0] opcode, funct;
    logic       ir_we, pc_we, reg_we, wb_mem_sel, link_sel, illegal_op, bus_err;
    logic [1:0] pc_src, reg_dst, alu_op;
    logic [2:0] state;
    out_t       obs;
    step_t      tq[$];
    int         checks, passes;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT(15), .CW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .bus        (bus),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .wb_mem_sel (wb_mem_sel),
        .link_sel   (link_sel),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .bus_err    (bus_err),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb obs = {state, bus.mem_req, bus.mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst,
                       wb_mem_sel, link_sel, alu_op, illegal_op, bus_err};

    function automatic bit legal(input logic [5:0] op);
        return op == OpR || op == OpAddi || op == OpLw || op == OpSw || op == OpBeq ||
               op == OpJ || op == OpJal;
    endfunction

    // Blank cycle in a given state; ack is random noise where it must be ignored
    function automatic step_t mk(input logic [2:0] st);
        step_t s;
        s.o    = '0;
        s.o.st = st;
        s.ack  = (st == 3'd0 || st == 3'd3) ? 1'b0 : 1'($urandom_range(0, 1));
        return s;
    endfunction

    // Wait cycles before ack; ok=0 when the watchdog fires first
    task automatic wait_phase(input logic [2:0] st, input int delay, input logic we,
                              output bit ok);
        step_t s;
        ok = 1'b0;
        for (int k = 0; k <= TMO; k++) begin
            if (k == delay) begin
                ok = 1'b1;
                return;
            end
            s = mk(st);
            s.o.req = 1'b1;
            s.o.we  = we;
            if (k == TMO) begin
                s.o.berr = 1'b1;
                tq.push_back(s);
                return;
            end
            tq.push_back(s);
        end
    endtask

    task automatic build(input logic [5:0] op, input logic z, input int fd, input int md);
        step_t s;
        bit    ok;
        tq.delete();
        wait_phase(3'd0, fd, 1'b0, ok);
        if (!ok) return;
        s = mk(3'd0);
        s.ack = 1'b1; s.o.req = 1'b1; s.o.ir_we = 1'b1; s.o.pc_we = 1'b1;
        tq.push_back(s);
        s = mk(3'd1);
        if (op == OpJ) begin
            s.o.pc_we = 1'b1; s.o.pc_src = 2'd2;
            tq.push_back(s);
            return;
        end
        if (op == OpJal) begin
            tq.push_back(s);
            s = mk(3'd5);
            s.o.reg_we = 1'b1; s.o.reg_dst = 2'd2; s.o.link = 1'b1;
            s.o.pc_we = 1'b1; s.o.pc_src = 2'd2;
            tq.push_back(s);
            return;
        end
        if (!legal(op)) begin
            s.o.ill = 1'b1;
            tq.push_back(s);
            return;
        end
        tq.push_back(s);
        s = mk(3'd2);
        s.o.alu = (op == OpR) ? 2'd2 : ((op == OpBeq) ? 2'd1 : 2'd0);
        if (op == OpBeq) begin
            s.o.pc_we = z; s.o.pc_src = 2'd1;
            tq.push_back(s);
            return;
        end
        tq.push_back(s);
        if (op == OpLw || op == OpSw) begin
            wait_phase(3'd3, md, op == OpSw, ok);
            if (!ok) return;
            s = mk(3'd3);
            s.ack = 1'b1; s.o.req = 1'b1; s.o.we = (op == OpSw);
            tq.push_back(s);
            if (op == OpSw) return;
        end
        s = mk(3'd4);
        s.o.reg_we = 1'b1; s.o.reg_dst = (op == OpR) ? 2'd1 : 2'd0; s.o.wbm = (op == OpLw);
        tq.push_back(s);
    endtask

    task automatic check(input out_t e, input string tag);
        checks++;
        assert (obs === e) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    endtask

    // Inputs change 1 time unit after posedge; outputs sampled at negedge
    task automatic play(input logic [5:0] op, input logic z, input int n, input string tag);
        opcode = op;
        zero   = z;
        funct  = 6'($urandom);
        for (int i = 0; i < tq.size() && i < n; i++) begin
            bus.mem_ack = tq[i].ack;
            @(negedge clk);
            check(tq[i].o, $sformatf("%s op=%h cyc%0d", tag, op, i));
            @(posedge clk);
            #1;
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic run(input logic [5:0] op, input logic z, input int fd, input int md,
                       input string tag);
        build(op, z, fd, md);
        play(op, z, 1000, tag);
    endtask

    task automatic reset_cycle(input string tag);
        rst = 1'b1;
        bus.mem_ack = 1'b1;
        opcode = 6'h3F;
        @(negedge clk);
        check('0, tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] op;
        int         fd, md;
        checks = 0;
        passes = 0;
        ops = '{OpR, OpAddi, OpLw, OpSw, OpBeq, OpJ, OpJal};
        rst = 1'b1; zero = 1'b0; opcode = 6'h0; funct = 6'h0; bus.mem_ack = 1'b0;

        reset_cycle("reset0");
        rst = 1'b1;
        reset_cycle("reset1");

        run(OpAddi, 1'b0, 0, 0, "addi");
        run(OpLw,   1'b0, 0, 3, "lw_delay3");
        run(OpJal,  1'b0, 0, 0, "jal");
        run(OpJ,    1'b0, 0, 0, "j");
        run(OpBeq,  1'b1, 0, 0, "beq_taken");
        run(OpBeq,  1'b0, 0, 0, "beq_not_taken");
        run(6'h3F,  1'b0, 0, 0, "illegal");
        run(OpR,    1'b0, 1, 0, "rtype");
        run(OpSw,   1'b0, 0, 2, "sw");
        run(OpAddi, 1'b0, 100, 0, "fetch_timeout");
        run(OpAddi, 1'b0, TMO, 0, "fetch_ack_last");
        run(OpLw,   1'b0, 0, 100, "mem_timeout");
        run(OpSw,   1'b0, 0, TMO, "mem_ack_last");

        // Reset in the middle of lw (just before MEM)
        build(OpLw, 1'b0, 0, 2);
        play(OpLw, 1'b0, 3, "lw_pre_rst");
        reset_cycle("mid_rst");
        run(OpAddi, 1'b0, 0, 0, "post_rst");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 6)];
            fd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17))
                                             : int'($urandom_range(0, 3));
            md = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17))
                                             : int'($urandom_range(0, 3));
            run(op, 1'($urandom_range(0, 1)), fd, md, "rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
